// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential shift-and-add multiplier, signed/unsigned, start/done handshake
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] pro
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   pro_q, pro_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_next;

    // Operands are processed as magnitudes; the sign is reapplied on completion.
    assign mag1 = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2 = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;

    assign sum       = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    assign prod_next = {sum, mplier_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        pro_d    = pro_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    // A zero operand never yields a negative result.
                    neg_d    = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]) & (|in1) & (|in2);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    pro_d   = neg_q ? -prod_next : prod_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            pro_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            pro_q    <= pro_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign pro  = pro_q;
endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - directed self-checking bench for seq_mul at WIDTH 8 and 4
module tb_seq_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, m8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] pro8;
    logic        s4, m4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  pro4;

    int checks = 0;
    int errors = 0;

    seq_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .signed_mode(m8),
        .in1(a8), .in2(b8), .busy(busy8), .done(done8), .pro(pro8)
    );

    seq_mul #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4), .signed_mode(m4),
        .in1(a4), .in2(b4), .busy(busy4), .done(done4), .pro(pro4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input string tag, input logic sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
        int cyc;
        int bcnt;
        @(negedge clk);
        s8 = 1'b1; m8 = sm; a8 = a; b8 = b;
        @(negedge clk);
        s8 = 1'b0; m8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        cyc  = 1;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) bcnt++;
        end
        check({tag, " pro"}, 32'(pro8), 32'(exp));
        check({tag, " latency"}, 32'(cyc), 32'd9);
        check({tag, " busy cycles"}, 32'(bcnt), 32'd8);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int cyc;
        @(negedge clk);
        s4 = 1'b1; m4 = 1'b0; a4 = a; b4 = b;
        @(negedge clk);
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        cyc = 1;
        while (!done4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("w4 %0d x %0d done", a, b), 32'(done4), 32'd1);
        check($sformatf("w4 %0d x %0d pro", a, b), 32'(pro4), 32'(exp));
    endtask

    initial begin
        int cyc;
        int dcnt;
        rst = 1'b1;
        s8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
        s4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset done", 32'(done8), 32'd0);
        check("reset pro", 32'(pro8), 32'd0);
        rst = 1'b0;

        op8("u 255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
        op8("s -128x-128", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s -3x5", 1'b1, 8'hFD, 8'd5, 16'hFFF1);
        op8("s 127x-1", 1'b1, 8'd127, 8'hFF, 16'hFF81);
        op8("u 0x200", 1'b0, 8'd0, 8'd200, 16'h0000);
        op8("s -56x0", 1'b1, 8'd200, 8'd0, 16'h0000);
        op8("u 200x3", 1'b0, 8'd200, 8'd3, 16'd600);

        // start during busy is ignored, then start in the done cycle
        @(negedge clk);
        s8 = 1'b1; m8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        s8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        @(negedge clk);
        s8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore done seen", 32'(done8), 32'd1);
        check("ignore pro", 32'(pro8), 32'd63);
        s8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
        @(negedge clk);
        s8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b latency", 32'(cyc), 32'd9);
        check("b2b pro", 32'(pro8), 32'd12);
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("no extra done", 32'(dcnt), 32'd0);
        check("pro held", 32'(pro8), 32'd12);

        // asynchronous reset mid-operation
        @(negedge clk);
        s8 = 1'b1; m8 = 1'b0; a8 = 8'd255; b8 = 8'd255;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy8), 32'd0);
        check("midrst done", 32'(done8), 32'd0);
        check("midrst pro", 32'(pro8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("post-reset done", 32'(dcnt), 32'd0);
        check("post-reset pro", 32'(pro8), 32'd0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op4(4'(i), 4'(j), 8'(i * j));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
